// File: rtl/conta3_pkg.sv
// rtl/conta3_pkg.sv - shared opcodes, FSM states and default widths for the conta3 sequencer
package conta3_pkg;

    localparam int CNT_W_DEF   = 3;
    localparam int PRESC_W_DEF = 8;
    localparam int ARG_W_DEF   = 8;
    localparam int CNT_MAX     = (1 << CNT_W_DEF) - 1;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_START  = 3'd2,
        OP_STOP   = 3'd3,
        OP_STEP   = 3'd4,
        OP_SETDIR = 3'd5,
        OP_BURST  = 3'd6,
        OP_RSVD   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

endpackage

// File: rtl/conta3_core.sv
// rtl/conta3_core.sv - counter register with load/step/direction; CONTA3_SAT_EN selects saturation instead of wrap
module conta3_core
    import conta3_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [CNT_W-1:0] q,
    output logic             hit,
    output logic             tc
);

    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] stepped;

    // limit in the current direction, the stepped value, and whether this step wraps or reaches the limit
    always_comb begin
        limit   = dir ? '0 : '1;
        stepped = dir ? (q - 1'b1) : (q + 1'b1);
`ifdef CONTA3_SAT_EN
        hit     = en && !load && (q != limit) && (stepped == limit);
`else
        hit     = en && !load && (q == limit);
`endif
    end

    // count register; load beats a step, and tc is the registered wrap/limit flag
    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            tc <= 1'b0;
        end else begin
            tc <= hit;
            if (load) begin
                q <= load_val;
            end else if (en) begin
`ifdef CONTA3_SAT_EN
                if (q != limit) begin
                    q <= stepped;
                end
`else
                q <= stepped;
`endif
            end
        end
    end

endmodule

// File: rtl/conta3_sched.sv
// rtl/conta3_sched.sv - command sequencer (FSM, prescaler, burst counter) driving conta3_core; honours CONTA3_SAT_EN
module conta3_sched
    import conta3_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int ARG_W   = ARG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [ARG_W-1:0] cmd_arg,
    output logic [CNT_W-1:0] cnt_q,
    output logic             tc_pulse,
    output logic             busy,
    output logic [1:0]       state_o
);

    state_t             state, state_n;
    logic               dir, dir_n;
    logic [PRESC_W-1:0] presc_reload, reload_n;
    logic [PRESC_W-1:0] presc_cnt, presc_n;
    logic [ARG_W-1:0]   burst_left, left_n;
    op_t                op;
    logic               accept, tick, load, step_en, restart, hit;

    assign cmd_ready = (state != ST_BURST);
    assign state_o   = state;

    conta3_core #(.CNT_W(CNT_W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (cmd_arg[CNT_W-1:0]),
        .en       (step_en),
        .dir      (dir),
        .q        (cnt_q),
        .hit      (hit),
        .tc       (tc_pulse)
    );

    // next-state decode: command effects, prescaler tick, burst countdown and saturation stop
    always_comb begin
        op       = op_t'(cmd_op);
        accept   = cmd_valid && cmd_ready;
        tick     = (state != ST_IDLE) && (presc_cnt == presc_reload);
        load     = accept && (op == OP_LOAD);
        state_n  = state;
        dir_n    = dir;
        reload_n = presc_reload;
        left_n   = burst_left;
        restart  = 1'b0;
        // a STOP landing on a tick leaves the count where it was
        step_en  = !load && ((tick && !(accept && op == OP_STOP)) ||
                             (accept && op == OP_STEP && state == ST_IDLE));
        if (accept) begin
            case (op)
                OP_START: begin
                    reload_n = cmd_arg[PRESC_W-1:0];
                    restart  = 1'b1;
                    state_n  = ST_RUN;
                end
                OP_STOP: begin
                    state_n = ST_IDLE;
                end
                OP_SETDIR: begin
                    dir_n = cmd_arg[0];
                end
                OP_BURST: begin
                    if (state == ST_IDLE && cmd_arg != '0) begin
                        left_n  = cmd_arg;
                        restart = 1'b1;
                        state_n = ST_BURST;
                    end
                end
                default: ;
            endcase
        end
        if (state == ST_BURST && tick) begin
            left_n = burst_left - 1'b1;
            if (burst_left == ARG_W'(1)) begin
                state_n = ST_IDLE;
            end
        end
`ifdef CONTA3_SAT_EN
        if (hit && state != ST_IDLE) begin
            state_n = ST_IDLE;
        end
`endif
        presc_n = (state_n == ST_IDLE || load || restart || tick) ? '0 : presc_cnt + 1'b1;
    end

    // sequencer registers; busy is registered alongside the state it reflects
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            dir          <= 1'b0;
            presc_reload <= '0;
            presc_cnt    <= '0;
            burst_left   <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            dir          <= dir_n;
            presc_reload <= reload_n;
            presc_cnt    <= presc_n;
            burst_left   <= left_n;
            busy         <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_conta3_sched.sv
// tb/tb_conta3_sched.sv - directed self-checking bench for conta3_sched (CONTA3_SAT_EN selects the saturating sequence)
module tb_conta3_sched;
    import conta3_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic [2:0] cnt_q;
    logic       tc_pulse;
    logic       busy;
    logic [1:0] state_o;

    typedef struct {
        string      tag;
        logic [2:0] cnt;
        logic       tc;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    conta3_sched dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cnt_q     (cnt_q),
        .tc_pulse  (tc_pulse),
        .busy      (busy),
        .state_o   (state_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input string tag, input logic r, input logic v, input op_t op,
                       input logic [7:0] arg, input logic [2:0] cnt, input logic tc,
                       input logic [1:0] st);
        exp_t e;
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
        e.tag = tag;
        e.cnt = cnt;
        e.tc  = tc;
        e.st  = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".cnt"},   8'(cnt_q),     8'(e.cnt));
        chk({e.tag, ".tc"},    8'(tc_pulse),  8'(e.tc));
        chk({e.tag, ".state"}, 8'(state_o),   8'(e.st));
        chk({e.tag, ".busy"},  8'(busy),      8'(e.st != 2'd0));
        chk({e.tag, ".ready"}, 8'(cmd_ready), 8'(e.st != 2'd2));
    endtask

    initial begin
        cyc("rst0", 1, 0, OP_NOP, 8'd0, 3'd0, 0, 2'd0);
        cyc("rst1", 1, 1, OP_LOAD, 8'd3, 3'd0, 0, 2'd0);
        cyc("load5", 0, 1, OP_LOAD, 8'd5, 3'd5, 0, 2'd0);
        cyc("idle5", 0, 0, OP_LOAD, 8'd2, 3'd5, 0, 2'd0);
`ifdef CONTA3_SAT_EN
        cyc("sat_start", 0, 1, OP_START, 8'd0, 3'd5, 0, 2'd1);
        cyc("sat_6", 0, 0, OP_NOP, 8'd0, 3'd6, 0, 2'd1);
        cyc("sat_7", 0, 0, OP_NOP, 8'd0, 3'd7, 1, 2'd0);
        cyc("sat_hold", 0, 0, OP_NOP, 8'd0, 3'd7, 0, 2'd0);
        cyc("sat_step", 0, 1, OP_STEP, 8'd0, 3'd7, 0, 2'd0);
        cyc("sat_step2", 0, 1, OP_STEP, 8'd0, 3'd7, 0, 2'd0);
`else
        cyc("load6", 0, 1, OP_LOAD, 8'd6, 3'd6, 0, 2'd0);
        cyc("run_start", 0, 1, OP_START, 8'd2, 3'd6, 0, 2'd1);
        cyc("run_p1", 0, 0, OP_NOP, 8'd0, 3'd6, 0, 2'd1);
        cyc("run_p2", 0, 0, OP_NOP, 8'd0, 3'd6, 0, 2'd1);
        cyc("run_7", 0, 0, OP_NOP, 8'd0, 3'd7, 0, 2'd1);
        cyc("run_7a", 0, 0, OP_NOP, 8'd0, 3'd7, 0, 2'd1);
        cyc("run_7b", 0, 0, OP_NOP, 8'd0, 3'd7, 0, 2'd1);
        cyc("run_wrap", 0, 0, OP_NOP, 8'd0, 3'd0, 1, 2'd1);
        cyc("run_0", 0, 0, OP_NOP, 8'd0, 3'd0, 0, 2'd1);
        cyc("run_step_ign", 0, 1, OP_STEP, 8'd0, 3'd0, 0, 2'd1);
        cyc("run_stop", 0, 1, OP_STOP, 8'd0, 3'd0, 0, 2'd0);
        cyc("fast_start", 0, 1, OP_START, 8'd0, 3'd0, 0, 2'd1);
        cyc("fast_1", 0, 0, OP_NOP, 8'd0, 3'd1, 0, 2'd1);
        cyc("fast_load3", 0, 1, OP_LOAD, 8'd3, 3'd3, 0, 2'd1);
        cyc("fast_4", 0, 0, OP_NOP, 8'd0, 3'd4, 0, 2'd1);
        cyc("fast_stop", 0, 1, OP_STOP, 8'd0, 3'd4, 0, 2'd0);
        cyc("b_load1", 0, 1, OP_LOAD, 8'd1, 3'd1, 0, 2'd0);
        cyc("b_setdir", 0, 1, OP_SETDIR, 8'd1, 3'd1, 0, 2'd0);
        cyc("b_start", 0, 1, OP_BURST, 8'd4, 3'd1, 0, 2'd2);
        cyc("b_0", 0, 1, OP_LOAD, 8'd2, 3'd0, 0, 2'd2);
        cyc("b_7", 0, 1, OP_LOAD, 8'd2, 3'd7, 1, 2'd2);
        cyc("b_6", 0, 1, OP_LOAD, 8'd2, 3'd6, 0, 2'd2);
        cyc("b_5", 0, 1, OP_LOAD, 8'd2, 3'd5, 0, 2'd0);
        cyc("step_dn", 0, 1, OP_STEP, 8'd0, 3'd4, 0, 2'd0);
        cyc("burst0", 0, 1, OP_BURST, 8'd0, 3'd4, 0, 2'd0);
        cyc("rsvd", 0, 1, OP_RSVD, 8'd5, 3'd4, 0, 2'd0);
        cyc("b2_start", 0, 1, OP_BURST, 8'd3, 3'd4, 0, 2'd2);
        cyc("b2_3", 0, 0, OP_NOP, 8'd0, 3'd3, 0, 2'd2);
        cyc("b2_rst", 1, 0, OP_NOP, 8'd0, 3'd0, 0, 2'd0);
        cyc("post_rst", 0, 0, OP_NOP, 8'd0, 3'd0, 0, 2'd0);
        cyc("step_up", 0, 1, OP_STEP, 8'd0, 3'd1, 0, 2'd0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
